uart_rx_framed: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports configurable data width, parity and stop-bit count, start-bit glitch rejection, framing/parity/overrun error flags, and a valid/ready output handshake. It sits between the board uart_rx pin and downstream consumers such as the LED driver, command parser or FIFO.

---
 rtl/uart_rx_framed_if.sv | 7 +
 rtl/uart_rx_framed.sv | 120 ++++++++++++
 tb/tb_uart_rx_framed.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framed_if.sv
// uart_rx_framed_if: received-word handshake bundle between the UART receiver and its consumer
interface uart_rx_framed_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] data_out;
   logic data_valid, data_ready, frame_err, parity_err, overrun, busy;
   modport master (output data_out, data_valid, frame_err, parity_err, overrun, busy, input data_ready);
   modport slave (input data_out, data_valid, frame_err, parity_err, overrun, busy, output data_ready);
endinterface

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with glitch rejection, error flags and valid/ready output
module uart_rx_framed #(
   parameter int DELAY_FRAMES = 234,
   parameter int DATA_BITS = 8,
   parameter int PARITY = 0,
   parameter int STOP_BITS = 1,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   input logic uart_rx,
   uart_rx_framed_if.master rx_if
);
   localparam int HALF = DELAY_FRAMES / 2;
   localparam int CW = $clog2(DELAY_FRAMES + 1);
   localparam int IW = $clog2(DATA_BITS);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DATA_BITS-1:0] sh_q, sh_d, out_q, out_d;
   logic stop_q, stop_d, fe_q, fe_d, pe_q, pe_d;
   logic valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d, busy_q;
   logic rx_s, tick, last_stop, fe_now, par_x, done, load;
   assign rx_s = sync_q[SYNC_STAGES-1];
   assign tick = cnt_q == CW'(DELAY_FRAMES);
   assign last_stop = stop_q == 1'(STOP_BITS - 1);
   assign fe_now = fe_q | ~rx_s;
   assign par_x = ^sh_q ^ rx_s;
   assign done = state_q == S_STOP && tick && last_stop;
   // a completed frame is dropped only if the previous word is still unaccepted
   assign load = done & (~valid_q | rx_if.data_ready);
   assign ovr_d = done & valid_q & ~rx_if.data_ready;
   assign valid_d = load | (valid_q & ~rx_if.data_ready);
   assign out_d = load ? sh_q : out_q;
   assign ferr_d = load ? fe_now : ferr_q;
   assign perr_d = load ? pe_q : perr_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      stop_d = stop_q;
      fe_d = fe_q;
      pe_d = pe_q;
      sh_d = sh_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = CW'(1);
            if (!rx_s) state_d = S_START;
         end
         S_START: if (cnt_q == CW'(HALF)) begin
            state_d = rx_s ? S_IDLE : S_DATA;
            cnt_d = CW'(1);
            idx_d = '0;
            stop_d = 1'b0;
            fe_d = 1'b0;
            pe_d = 1'b0;
         end
         S_DATA: if (tick) begin
            cnt_d = CW'(1);
            sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DATA_BITS - 1)) state_d = PARITY != 0 ? S_PAR : S_STOP;
         end
         S_PAR: if (tick) begin
            cnt_d = CW'(1);
            pe_d = PARITY == 1 ? ~par_x : par_x;
            state_d = S_STOP;
         end
         S_STOP: if (tick) begin
            cnt_d = CW'(1);
            fe_d = fe_now;
            stop_d = stop_q + 1'b1;
            if (last_stop) state_d = fe_now ? S_BRK : S_IDLE;
         end
         S_BRK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sync_q <= '1;
         cnt_q <= '0;
         idx_q <= '0;
         sh_q <= '0;
         out_q <= '0;
         stop_q <= 1'b0;
         fe_q <= 1'b0;
         pe_q <= 1'b0;
         valid_q <= 1'b0;
         ferr_q <= 1'b0;
         perr_q <= 1'b0;
         ovr_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         sh_q <= sh_d;
         out_q <= out_d;
         stop_q <= stop_d;
         fe_q <= fe_d;
         pe_q <= pe_d;
         valid_q <= valid_d;
         ferr_q <= ferr_d;
         perr_q <= perr_d;
         ovr_q <= ovr_d;
         busy_q <= state_d != S_IDLE;
      end
   end
   assign rx_if.data_out = out_q;
   assign rx_if.data_valid = valid_q;
   assign rx_if.frame_err = ferr_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.overrun = ovr_q;
   assign rx_if.busy = busy_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed scoreboard bench over three receiver configurations
module tb_uart_rx_framed;
   localparam int D = 16;
   localparam int HALF = D / 2;
   localparam int SYNC = 2;
   localparam int T_VALID = SYNC + 1 + HALF + 9 * D;
   typedef struct {int id; logic [8:0] d; logic fe; logic pe;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] line = 3'b111;
   exp_t exp_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int nv[3] = '{0, 0, 0};
   int novr[3] = '{0, 0, 0};
   int t_rise[3] = '{0, 0, 0};
   bit pv[3] = '{0, 0, 0};
   uart_rx_framed_if #(.DATA_BITS(8)) ia ();
   uart_rx_framed_if #(.DATA_BITS(7)) ib ();
   uart_rx_framed_if #(.DATA_BITS(8)) ic ();
   uart_rx_framed #(.DELAY_FRAMES(D)) dut_a (.clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .rx_if(ia));
   uart_rx_framed #(.DELAY_FRAMES(D), .DATA_BITS(7), .PARITY(2)) dut_b (.clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .rx_if(ib));
   uart_rx_framed #(.DELAY_FRAMES(D), .STOP_BITS(2)) dut_c (.clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .rx_if(ic));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int id, input logic [8:0] d, input logic fe, input logic pe);
      exp_t e;
      e.id = id; e.d = d; e.fe = fe; e.pe = pe;
      exp_q.push_back(e);
   endtask

   task automatic mon(input int id, input logic v, input logic r, input logic [8:0] d, input logic fe, input logic pe, input logic ov);
      exp_t e;
      if (ov) novr[id]++;
      if (v) nv[id]++;
      if (v && !pv[id]) t_rise[id] = cyc;
      pv[id] = v;
      if (v && r) begin
         if (exp_q.size() == 0) chk($sformatf("word_expected_dut%0d", id), 32'(exp_q.size() != 0), 1);
         else begin
            e = exp_q.pop_front();
            chk($sformatf("dut_id%0d", id), id, e.id);
            chk($sformatf("data_dut%0d", id), d, e.d);
            chk($sformatf("frame_err_dut%0d", id), fe, e.fe);
            chk($sformatf("parity_err_dut%0d", id), pe, e.pe);
         end
      end
   endtask

   always @(negedge clk) begin
      #2;
      mon(0, ia.data_valid, ia.data_ready, 9'(ia.data_out), ia.frame_err, ia.parity_err, ia.overrun);
      mon(1, ib.data_valid, ib.data_ready, 9'(ib.data_out), ib.frame_err, ib.parity_err, ib.overrun);
      mon(2, ic.data_valid, ic.data_ready, 9'(ic.data_out), ic.frame_err, ic.parity_err, ic.overrun);
   end

   // called right after a negedge; leaves the line at the last stop-bit level
   task automatic send(input int id, input logic [8:0] d, input int nb, input int par, input int nstop, input logic stop_v);
      line[id] = 1'b0;
      repeat (D) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         line[id] = d[i];
         repeat (D) @(negedge clk);
      end
      if (par >= 0) begin
         line[id] = par[0];
         repeat (D) @(negedge clk);
      end
      for (int s = 0; s < nstop; s++) begin
         line[id] = stop_v;
         repeat (D) @(negedge clk);
      end
   endtask

   initial begin
      int c0, v0, bc;
      ia.data_ready = 1'b1; ib.data_ready = 1'b1; ic.data_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_valid", ia.data_valid, 0);
      chk("rst_data", ia.data_out, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_ovr", ia.overrun, 0);
      chk("rst_ferr", ic.frame_err, 0);
      chk("rst_perr", ib.parity_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      // 8N1 0x55, timing and single-cycle pulse
      push(0, 9'h55, 0, 0);
      v0 = nv[0];
      c0 = cyc;
      send(0, 9'h55, 8, -1, 1, 1'b1);
      repeat (2 * D) @(negedge clk);
      chk("valid_latency", t_rise[0] - c0, T_VALID);
      chk("valid_pulse_len", nv[0] - v0, 1);
      // start-bit glitch
      bc = 0;
      v0 = nv[0];
      for (int i = 0; i < 40; i++) begin
         line[0] = (i >= 4);
         @(negedge clk);
         #3;
         if (ia.busy) bc++;
      end
      chk("glitch_busy_window", 32'(bc >= 1 && bc <= HALF + SYNC + 1), 1);
      chk("glitch_no_word", nv[0] - v0, 0);
      chk("glitch_idle", ia.busy, 0);
      // even parity, 7 data bits
      push(1, 9'h41, 0, 0);
      send(1, 9'h41, 7, 0, 1, 1'b1);
      push(1, 9'h41, 0, 1);
      send(1, 9'h41, 7, 1, 1, 1'b1);
      repeat (D) @(negedge clk);
      // low stop bit followed by a held-low line
      push(0, 9'hA3, 1, 0);
      v0 = nv[0];
      send(0, 9'hA3, 8, -1, 1, 1'b0);
      repeat (5 * D) @(negedge clk);
      line[0] = 1'b1;
      repeat (3 * D) @(negedge clk);
      chk("break_one_word", nv[0] - v0, 1);
      push(0, 9'h5A, 0, 0);
      send(0, 9'h5A, 8, -1, 1, 1'b1);
      repeat (D) @(negedge clk);
      // overrun with consumer stalled
      ia.data_ready = 1'b0;
      push(0, 9'h12, 0, 0);
      send(0, 9'h12, 8, -1, 1, 1'b1);
      send(0, 9'h34, 8, -1, 1, 1'b1);
      repeat (4) @(negedge clk);
      #3;
      chk("ovr_count", novr[0], 1);
      chk("ovr_hold_valid", ia.data_valid, 1);
      chk("ovr_hold_data", ia.data_out, 8'h12);
      @(negedge clk);
      ia.data_ready = 1'b1;
      @(negedge clk);
      #3;
      chk("valid_drop", ia.data_valid, 0);
      // two stop bits, back to back
      push(2, 9'hFF, 0, 0);
      send(2, 9'hFF, 8, -1, 2, 1'b1);
      push(2, 9'h00, 0, 0);
      send(2, 9'h00, 8, -1, 2, 1'b1);
      repeat (D) @(negedge clk);
      // mid-frame async reset with a pending word
      ic.data_ready = 1'b0;
      send(2, 9'h5C, 8, -1, 2, 1'b1);
      repeat (4) @(negedge clk);
      #3;
      chk("pend_valid", ic.data_valid, 1);
      chk("pend_data", ic.data_out, 8'h5C);
      @(negedge clk);
      line[2] = 1'b0;
      repeat (3 * D) @(negedge clk);
      chk("midframe_busy", ic.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", ic.data_valid, 0);
      chk("arst_data", ic.data_out, 0);
      chk("arst_busy", ic.busy, 0);
      chk("arst_ferr", ic.frame_err, 0);
      line[2] = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ic.data_ready = 1'b1;
      repeat (D) @(negedge clk);
      push(2, 9'h3C, 0, 0);
      send(2, 9'h3C, 8, -1, 2, 1'b1);
      for (int i = 0; i < 10 * D && exp_q.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
